// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the MDU sequencer: ALU op codes, MDU op codes and
// FSM state encodings.
package mdu_sequencer_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mdu_sequencer_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a
// restoring-divide step, built around a single add/subtract.
module mdu_sequencer_step
    import mdu_sequencer_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] acc,
    input  logic [NBITS-1:0] oreg,
    input  logic [NBITS-1:0] opnd,
    input  logic             is_div,
    output logic [NBITS-1:0] acc_nx,
    output logic [NBITS-1:0] oreg_nx
);

    logic [3:0]     alu_op;
    logic [NBITS:0] a_in;
    logic [NBITS:0] b_in;
    logic [NBITS:0] sum;
    logic [NBITS:0] keep;

    // Divide: trial-subtract divisor from {rem, next dividend bit};
    // multiply: conditionally add multiplicand, then shift {acc, oreg} right.
    always_comb begin
        alu_op  = is_div ? ALU_SUB : ALU_ADD;
        a_in    = is_div ? {acc, oreg[NBITS-1]} : {1'b0, acc};
        b_in    = {1'b0, opnd};
        sum     = (alu_op == ALU_SUB) ? (a_in - b_in) : (a_in + b_in);
        keep    = '0;
        acc_nx  = acc;
        oreg_nx = oreg;
        if (is_div) begin
            // sum[NBITS] is the borrow: set means the trial went negative
            if (!sum[NBITS]) begin
                acc_nx  = sum[NBITS-1:0];
                oreg_nx = {oreg[NBITS-2:0], 1'b1};
            end else begin
                acc_nx  = a_in[NBITS-1:0];
                oreg_nx = {oreg[NBITS-2:0], 1'b0};
            end
        end else begin
            keep    = oreg[0] ? sum : {1'b0, acc};
            acc_nx  = keep[NBITS:1];
            oreg_nx = {keep[0], oreg[NBITS-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional macro MDU_EARLY_OUT_EN: multiplies finish early once the
// remaining multiplier bits are all zero.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int MOPBITS = 2,
    parameter int CNTBITS = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Start,
    input  logic [MOPBITS-1:0] i_Op,
    input  logic [NBITS-1:0]   i_RegA,
    input  logic [NBITS-1:0]   i_RegB,
    input  logic               i_WriteHi,
    input  logic               i_WriteLo,
    input  logic [NBITS-1:0]   i_WriteData,
    output logic               o_Busy,
    output logic               o_Done,
    output logic [NBITS-1:0]   o_Hi,
    output logic [NBITS-1:0]   o_Lo
);

    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(NBITS - 1);

    state_t             state, state_nx;
    logic [CNTBITS-1:0] cnt;
    logic [NBITS-1:0]   acc, oreg, opnd, a_q;
    logic [NBITS-1:0]   acc_nx, oreg_nx, hi_res, lo_res;
    logic [NBITS-1:0]   a_mag, b_mag;
    logic [2*NBITS-1:0] prod, calc_nx;
    logic               div_q, neg_q, rneg_q, bz_q;
    logic               st_div, st_sgn, a_neg, b_neg, early;

    mdu_sequencer_step #(.NBITS(NBITS)) u_step (
        .acc     (acc),
        .oreg    (oreg),
        .opnd    (opnd),
        .is_div  (div_q),
        .acc_nx  (acc_nx),
        .oreg_nx (oreg_nx)
    );

    // Decode the incoming op and take operand magnitudes for signed ops
    always_comb begin
        st_div = (i_Op == MOPBITS'(MDU_DIV))  || (i_Op == MOPBITS'(MDU_DIVU));
        st_sgn = (i_Op == MOPBITS'(MDU_MULT)) || (i_Op == MOPBITS'(MDU_DIV));
        a_neg  = st_sgn & i_RegA[NBITS-1];
        b_neg  = st_sgn & i_RegB[NBITS-1];
        a_mag  = a_neg ? -i_RegA : i_RegA;
        b_mag  = b_neg ? -i_RegB : i_RegB;
    end

`ifdef MDU_EARLY_OUT_EN
    logic [NBITS-1:0]   mrem;
    logic [CNTBITS-1:0] shamt;

    // mrem[0] is the multiplier bit consumed this step; above it is what's left
    assign early   = !div_q && ((mrem >> 1) == '0);
    assign shamt   = CNT_LAST - cnt;
    assign calc_nx = early ? ({acc_nx, oreg_nx} >> shamt) : {acc_nx, oreg_nx};

    // Shadow copy of the multiplier, shifted without refill, for the zero test
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                          mrem <= '0;
        else if (state == ST_IDLE && i_Start) mrem <= b_mag;
        else if (state == ST_CALC)            mrem <= mrem >> 1;
    end
`else
    assign early   = 1'b0;
    assign calc_nx = {acc_nx, oreg_nx};
`endif

    // Sign correction and divide special cases applied in FIX
    always_comb begin
        prod = {acc, oreg};
        if (neg_q) prod = -prod;
        hi_res = prod[2*NBITS-1:NBITS];
        lo_res = prod[NBITS-1:0];
        if (div_q) begin
            if (bz_q) begin
                hi_res = a_q;
                lo_res = '1;
            end else begin
                lo_res = neg_q  ? -oreg : oreg;
                hi_res = rneg_q ? -acc  : acc;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (i_Start) state_nx = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST || early) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath, counter and HI/LO
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0; acc <= '0; oreg <= '0; opnd <= '0; a_q <= '0;
            div_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0; bz_q <= 1'b0;
            o_Hi <= '0; o_Lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_WriteHi) o_Hi <= i_WriteData;
                    if (i_WriteLo) o_Lo <= i_WriteData;
                    if (i_Start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        oreg   <= st_div ? a_mag : b_mag;
                        opnd   <= st_div ? b_mag : a_mag;
                        a_q    <= i_RegA;
                        div_q  <= st_div;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        bz_q   <= (i_RegB == '0);
                    end
                end
                ST_CALC: begin
                    cnt         <= cnt + 1'b1;
                    {acc, oreg} <= calc_nx;
                end
                ST_FIX: begin
                    o_Hi <= hi_res;
                    o_Lo <= lo_res;
                end
                default: ;
            endcase
        end
    end

    assign o_Busy = (state == ST_CALC) || (state == ST_FIX);
    assign o_Done = (state == ST_DONE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: scoreboard of expected HI/LO
// pushed at each start and popped when o_Done pulses.
module tb_mdu_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset, i_Start, i_WriteHi, i_WriteLo;
    logic [1:0]  i_Op;
    logic [31:0] i_RegA, i_RegB, i_WriteData;
    logic        o_Busy, o_Done;
    logic [31:0] o_Hi, o_Lo;

    typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;
    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef MDU_EARLY_OUT_EN
    bit early_build = 1'b1;
`else
    bit early_build = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    mdu_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_Start(i_Start), .i_Op(i_Op),
        .i_RegA(i_RegA), .i_RegB(i_RegB), .i_WriteHi(i_WriteHi),
        .i_WriteLo(i_WriteLo), .i_WriteData(i_WriteData),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Hi(o_Hi), .o_Lo(o_Lo)
    );

    // Wait for IDLE, push the expected result, pulse start; returns at cycle 1
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, b,
                            input logic [31:0] ehi, elo);
        int n = 0;
        @(negedge i_clk);
        while ((o_Busy || o_Done) && n < 100) begin @(negedge i_clk); n++; end
        sb.push_back({ehi, elo});
        i_Op = op; i_RegA = a; i_RegB = b; i_Start = 1'b1;
        @(posedge i_clk); #1;
        i_Start = 1'b0;
    endtask

    // Count cycles (first sample after start edge is cycle c0) until o_Done
    task automatic run_to_done(input int c0, output int lat, output int busy);
        lat = -1; busy = 0;
        for (int c = c0; c <= 120; c++) begin
            if (o_Done) begin lat = c; break; end
            if (o_Busy) busy++;
            @(posedge i_clk); #1;
        end
    endtask

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, b);
        logic [63:0] p;
        int sa, sbv;
        res_t r;
        sa = a; sbv = b;
        case (op)
            2'b00: begin p = longint'(sa) * longint'(sbv); r = {p[63:32], p[31:0]}; end
            2'b01: begin p = {32'h0, a} * {32'h0, b};      r = {p[63:32], p[31:0]}; end
            2'b10: begin
                if (b == 0)                                 r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)     r = {32'h0, 32'h8000_0000};
                else                                        r = {32'(sa % sbv), 32'(sa / sbv)};
            end
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return r;
    endfunction

    task automatic test_reset();
        i_reset = 1'b1; i_Start = 0; i_WriteHi = 0; i_WriteLo = 0;
        i_Op = 0; i_RegA = 0; i_RegB = 0; i_WriteData = 0;
        #2;
        checks += 4;
        if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_Busy); end
        if (o_Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_Done); end
        if (o_Hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h want 0", o_Hi); end
        if (o_Lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h want 0", o_Lo); end
        @(negedge i_clk); i_reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat, busy; res_t e;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_to_done(1, lat, busy);
        e = sb.pop_front();
        checks += 5;
        if (lat != 34)   begin errors++; $display("FAIL multu_lat got %0d want 34", lat); end
        if (busy != 33)  begin errors++; $display("FAIL multu_busy got %0d want 33", busy); end
        if (o_Hi !== e.hi) begin errors++; $display("FAIL multu_hi got %h want %h", o_Hi, e.hi); end
        if (o_Lo !== e.lo) begin errors++; $display("FAIL multu_lo got %h want %h", o_Lo, e.lo); end
        @(posedge i_clk); #1;
        if (o_Done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", o_Done); end
    endtask

    // Signed ops and divide corner cases from a fixed table
    task automatic test_corners();
        logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bs  [5] = '{32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehs [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'hFFFF_FFF9};
        logic [31:0] els [5] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        int lat, busy; res_t e;
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], as[i], bs[i], ehs[i], els[i]);
            run_to_done(1, lat, busy);
            e = sb.pop_front();
            checks += 2;
            if (o_Hi !== e.hi) begin errors++; $display("FAIL corner%0d_hi got %h want %h", i, o_Hi, e.hi); end
            if (o_Lo !== e.lo) begin errors++; $display("FAIL corner%0d_lo got %h want %h", i, o_Lo, e.lo); end
            if (ops[i][1] || !early_build) begin
                checks++;
                if (lat != 34) begin errors++; $display("FAIL corner%0d_lat got %0d want 34", i, lat); end
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat, busy; res_t e;
        int pc = early_build ? 2 : 10;
        start_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        repeat (pc - 1) @(posedge i_clk);
        #1;
        i_Op = 2'b11; i_RegA = 32'd100; i_RegB = 32'd3; i_Start = 1'b1;
        i_WriteLo = 1'b1; i_WriteHi = 1'b1; i_WriteData = 32'hAAAA;
        @(posedge i_clk); #1;
        i_Start = 1'b0; i_WriteLo = 1'b0; i_WriteHi = 1'b0;
        run_to_done(pc + 1, lat, busy);
        e = sb.pop_front();
        checks += 2;
        if (o_Hi !== e.hi) begin errors++; $display("FAIL ignore_hi got %h want %h", o_Hi, e.hi); end
        if (o_Lo !== e.lo) begin errors++; $display("FAIL ignore_lo got %h want %h", o_Lo, e.lo); end
        if (!early_build) begin
            checks++;
            if (lat != 34) begin errors++; $display("FAIL ignore_lat got %0d want 34", lat); end
        end
        // A write in DONE must lose to the result
        i_WriteLo = 1'b1; i_WriteData = 32'h5A5A;
        @(posedge i_clk); #1; i_WriteLo = 1'b0;
        checks++;
        if (o_Lo !== e.lo) begin errors++; $display("FAIL done_write got %h want %h", o_Lo, e.lo); end
    endtask

    task automatic test_write_start();
        int lat, busy; res_t e;
        i_WriteLo = 1'b1; i_WriteData = 32'hBEEF;
        start_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
        i_WriteLo = 1'b0;
        checks++;
        if (o_Lo !== 32'hBEEF) begin errors++; $display("FAIL ws_write got %h want 0000beef", o_Lo); end
        run_to_done(1, lat, busy);
        e = sb.pop_front();
        checks++;
        if (o_Lo !== e.lo) begin errors++; $display("FAIL ws_result got %h want %h", o_Lo, e.lo); end
    endtask

    task automatic test_abort();
        int seen = 0;
        start_op(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);
        repeat (14) @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        void'(sb.pop_back());
        checks += 3;
        if (o_Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", o_Busy); end
        if (o_Hi !== 32'h0)  begin errors++; $display("FAIL abort_hi got %h want 0", o_Hi); end
        if (o_Lo !== 32'h0)  begin errors++; $display("FAIL abort_lo got %h want 0", o_Lo); end
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        for (int c = 0; c < 40; c++) begin @(posedge i_clk); #1; if (o_Done) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", seen); end
        @(negedge i_clk); i_WriteHi = 1'b1; i_WriteData = 32'h55;
        @(posedge i_clk); #1; i_WriteHi = 1'b0;
        checks++;
        if (o_Hi !== 32'h55) begin errors++; $display("FAIL mthi got %h want 00000055", o_Hi); end
    endtask

    task automatic test_early_out();
        int lat, busy; res_t e;
        start_op(2'b01, 32'h1234_5678, 32'd1, 32'h0, 32'h1234_5678);
        run_to_done(1, lat, busy);
        e = sb.pop_front();
        checks += 3;
        if (o_Hi !== e.hi) begin errors++; $display("FAIL early_hi got %h want %h", o_Hi, e.hi); end
        if (o_Lo !== e.lo) begin errors++; $display("FAIL early_lo got %h want %h", o_Lo, e.lo); end
        if (early_build ? (lat < 1 || lat > 3) : (lat != 34)) begin
            errors++; $display("FAIL early_lat got %0d want %0d", lat, early_build ? 3 : 34);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy; res_t e, m;
        logic [1:0] op; logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            m  = model(op, a, b);
            start_op(op, a, b, m.hi, m.lo);
            run_to_done(1, lat, busy);
            e = sb.pop_front();
            checks += 2;
            if (lat < 0) $display("FAIL b2b%0d_timeout op %0d", i, op);
            if (o_Hi !== e.hi) begin errors++; $display("FAIL b2b%0d_hi op %0d a %h b %h got %h want %h", i, op, a, b, o_Hi, e.hi); end
            if (o_Lo !== e.lo) begin errors++; $display("FAIL b2b%0d_lo op %0d a %h b %h got %h want %h", i, op, a, b, o_Lo, e.lo); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_corners();
        test_ignored_start();
        test_write_start();
        test_abort();
        test_early_out();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the EX stage; runs MULT, MULTU, DIV and DIVU iteratively and owns the architectural HI/LO registers.
- Each iteration is one add/subtract step on the shared adder datapath; the sequencer supplies the operands and ALU op codes (ADD 4'b0010, SUB 4'b0110).
- The hazard unit reads o_Busy to stall MFHI/MFLO and any new MDU instruction.

Parameters:
- NBITS, 32, operand/HI/LO width.
- MOPBITS, 2, MDU opcode width.
- CNTBITS, 6, iteration counter width; must satisfy 2^CNTBITS > NBITS.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  asynchronous active-high reset.
- i_Start  input  1  start request, sampled on the rising edge.
- i_Op  input  MOPBITS  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_RegA  input  NBITS  rs (multiplicand/dividend).
- i_RegB  input  NBITS  rt (multiplier/divisor).
- i_WriteHi  input  1  MTHI strobe.
- i_WriteLo  input  1  MTLO strobe.
- i_WriteData  input  NBITS  MTHI/MTLO data.
- o_Busy  output  1  operation in progress (CALC or FIX).
- o_Done  output  1  one-cycle pulse, HI/LO updated.
- o_Hi  output  NBITS  HI register.
- o_Lo  output  NBITS  LO register.

Behaviour:
- Clock and reset: i_clk with asynchronous active-high i_reset. Reset forces state IDLE and sets o_Hi=0, o_Lo=0, o_Busy=0, o_Done=0. Reset asserted mid-operation aborts it; HI/LO keep no partial result.
- FSM states and transitions:
  - IDLE: i_Start=1 latches operands and op, goes to CALC, counter=0.
  - CALC: one step per cycle. After NBITS steps (counter==NBITS-1), goes to FIX.
  - FIX: applies sign correction; HI/LO written on the FIX->DONE edge.
  - DONE: o_Done=1 for exactly one cycle, then IDLE.
- Latency: start edge to o_Done high takes NBITS+2 cycles (34 at default). o_Busy is high in CALC and FIX only.
- Signed ops: iterate on operand magnitudes.
  - MULT: negate the 2*NBITS product if the operand signs differ.
  - DIV: quotient negative if the signs differ; remainder takes the dividend's sign.
- Multiply: shift-add. The 2*NBITS product is held in {acc, multiplier}; LO=low half, HI=high half.
- Divide: restoring. LO=quotient, HI=remainder.
- Divide by zero (DIV or DIVU): LO=all ones, HI=i_RegA as latched. No exception raised.
- DIV of -2^(NBITS-1) by -1: LO=2^(NBITS-1) (0x80000000), HI=0.
- Start handling:
  - i_Start while not IDLE is ignored; no queueing.
  - i_Start in DONE is also ignored. The pipeline must wait for o_Busy=0 and the DONE cycle to clear.
- MTHI/MTLO writes:
  - i_WriteHi/i_WriteLo take effect next edge only when state is IDLE; they are ignored otherwise.
  - A write and i_Start in the same IDLE cycle: the write applies, the start is accepted, and the later result overwrites HI/LO.
  - Write in DONE: ignored; the result wins.
- Operands are latched at start; changes on i_RegA/i_RegB during CALC have no effect.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: for MULT/MULTU in CALC, if the remaining unshifted multiplier bits are all zero, the FSM skips to FIX on the next edge, with the product shifted into its correct alignment. Latency is then data-dependent, minimum 3 cycles (for example multiplier=0 or 1). Divide is unaffected.
- Undefined: fixed NBITS+2 latency for all ops.

Decomposition:
- Shared package holds:
  - the ALU op constants (AND, OR, ADD, SUB, SLT, NOR, XOR, SLL, SRL, SRA);
  - MDU op codes MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU;
  - FSM state encodings ST_IDLE/ST_CALC/ST_FIX/ST_DONE.
- One sub-module is natural: mdu_step, combinational. It takes {acc, operand reg, divisor/multiplicand, op} and produces the next {acc, operand reg} for one shift-add or restoring-subtract step. The FSM, counter and HI/LO stay in mdu_sequencer.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> o_Done 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; o_Busy high for cycles 1-33.
- MULT A=-3 B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=0x12345678 B=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULTU 6*7, pulse i_Start with DIVU and i_WriteLo=0xAAAA at cycle 10 -> both ignored; HI=0, LO=42.
- Start DIV, assert i_reset at cycle 15 -> o_Busy=0, HI=LO=0 immediately; no o_Done. After release, MTHI 0x55 in IDLE -> HI=0x55 next cycle.
- With MDU_EARLY_OUT_EN: MULTU 0x12345678*1 -> o_Done within 3 cycles, LO=0x12345678, HI=0. Without the macro -> 34 cycles, same result.
